// File: rtl/ascon_block_packer_pkg.sv
// Shared types and constants for the Ascon block packer.
//   kind_t  : tag on each input word (key / nonce / associated data / plaintext)
//   state_t : packer sequencing states
package ascon_block_packer_pkg;

   localparam int         WORD_W       = 32;
   localparam int         BLK_W        = 128;
   localparam int         WORDS_PER_BLK = BLK_W / WORD_W;
   localparam logic [7:0] PAD_BYTE_DEF = 8'h80;

   typedef enum logic [1:0] {
      KIND_KEY   = 2'b00,
      KIND_NONCE = 2'b01,
      KIND_AD    = 2'b10,
      KIND_PT    = 2'b11
   } kind_t;

   typedef enum logic [2:0] {
      S_KEY  = 3'd0,
      S_GO   = 3'd1,
      S_AD   = 3'd2,
      S_SEP  = 3'd3,
      S_PT   = 3'd4,
      S_PAD  = 3'd5,
      S_SEND = 3'd6
   } state_t;

endpackage

// File: rtl/ascon_block_packer_pad.sv
// Tail-word masking for Ascon 10* padding (combinational).
//   word_i   : raw input word, byte 0 = word_i[31:24]
//   nbytes_i : number of valid bytes (0..4)
//   pad_en_i : insert PAD_BYTE directly after the last valid byte
//   word_o   : valid bytes kept, pad byte inserted, remaining bytes zero
module ascon_pad_word
   import ascon_block_packer_pkg::*;
#(
   parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEF
) (
   input  logic [WORD_W-1:0] word_i,
   input  logic [2:0]        nbytes_i,
   input  logic              pad_en_i,
   output logic [WORD_W-1:0] word_o
);

   always_comb begin
      word_o = '0;
      for (int i = 0; i < 4; i++) begin
         if (3'(i) < nbytes_i) begin
            word_o[WORD_W-1-8*i -: 8] = word_i[WORD_W-1-8*i -: 8];
         end else if (pad_en_i && (3'(i) == nbytes_i)) begin
            word_o[WORD_W-1-8*i -: 8] = PAD_BYTE;
         end
      end
   end

endmodule

// File: rtl/ascon_block_packer.sv
// Ascon core loader: packs a tagged 32-bit word stream into 128-bit blocks,
// applies 10* padding to AD/PT tails, inserts the AD->PT separator beat and
// issues the one-cycle key_go start pulse once key and nonce are delivered.
//   clk, rst           : clock, asynchronous active-low reset
//   s_data/s_kind/...  : input word stream (valid/ready), s_bytes on last word
//   blk, blk_valid     : block to core, held until core_ready
//   blk_k_n, blk_a_p   : key/nonce select, separator flag
//   key_go             : core start pulse
//   err                : sticky protocol error
//
// state  | meaning
// S_KEY  | filling key / nonce blocks
// S_GO   | key_go pulse high
// S_AD   | filling associated-data blocks (or waiting for first PT word)
// S_SEP  | separator beat pending
// S_PT   | filling plaintext blocks
// S_PAD  | load extra {PAD_BYTE,0} block after a block-aligned tail
// S_SEND | block pending, wait for core_ready then return to ret_q
module ascon_block_packer
   import ascon_block_packer_pkg::*;
#(
   parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [1:0]        s_kind,
   input  logic              s_last,
   input  logic [2:0]        s_bytes,
   output logic [BLK_W-1:0]  blk,
   output logic              blk_valid,
   output logic              blk_k_n,
   output logic              blk_a_p,
   output logic              key_go,
   input  logic              core_ready,
   output logic              err
);

   state_t            state_q, state_d;
   state_t            ret_q, ret_d;
   logic [1:0]        w_q, w_d;
   logic [BLK_W-1:0]  blk_q, blk_d;
   logic              blk_valid_q, blk_valid_d;
   logic              blk_k_n_q, blk_k_n_d;
   logic              blk_a_p_q, blk_a_p_d;
   logic              key_go_q, key_go_d;
   logic              err_q, err_d;
   logic              key_seen_q, key_seen_d;
   logic              nonce_seen_q, nonce_seen_d;
   kind_t             seg_kind_q, seg_kind_d;

   kind_t             kind;
   logic              fill_state;
   logic              sep_stall;
   logic              word_xfer;
   logic              blk_xfer;
   logic              bytes_ok;
   logic [2:0]        nbytes;
   logic              pad_en;
   logic [WORD_W-1:0] tail_word;
   kind_t             data_kind;
   state_t            done_state;

   assign kind       = kind_t'(s_kind);
   assign fill_state = (state_q == S_KEY) || (state_q == S_AD) || (state_q == S_PT);
   // First PT word after AD is held off until the separator beat has gone out.
   assign sep_stall  = (state_q == S_AD) && s_valid && (kind == KIND_PT) && (w_q == 2'd0);
   // Gated by rst so every output reads 0 while reset is asserted.
   assign s_ready    = rst && fill_state && !blk_valid_q && !key_go_q && !sep_stall;
   assign word_xfer  = s_valid && s_ready;
   assign blk_xfer   = blk_valid_q && core_ready;
   assign bytes_ok   = (s_bytes != 3'd0) && (s_bytes <= 3'd4);
   assign nbytes     = s_last ? s_bytes : 3'd4;
   assign pad_en     = s_last && (s_bytes < 3'd4);
   assign data_kind  = (state_q == S_AD) ? KIND_AD : KIND_PT;
   assign done_state = (kind == KIND_PT) ? S_KEY : S_AD;

   ascon_pad_word #(.PAD_BYTE(PAD_BYTE)) u_pad (
      .word_i   (s_data),
      .nbytes_i (nbytes),
      .pad_en_i (pad_en),
      .word_o   (tail_word)
   );

   always_comb begin
      state_d      = state_q;
      ret_d        = ret_q;
      w_d          = w_q;
      blk_d        = blk_q;
      blk_valid_d  = blk_valid_q;
      blk_k_n_d    = blk_k_n_q;
      blk_a_p_d    = blk_a_p_q;
      key_go_d     = 1'b0;
      err_d        = err_q;
      key_seen_d   = key_seen_q;
      nonce_seen_d = nonce_seen_q;
      seg_kind_d   = seg_kind_q;

      case (state_q)
         S_KEY: begin
            if (word_xfer) begin
               if ((kind == KIND_AD) || (kind == KIND_PT)) begin
                  err_d = 1'b1;
               end else if ((w_q != 2'd0) && (kind != seg_kind_q)) begin
                  err_d = 1'b1;
                  w_d   = 2'd0;
                  blk_d = '0;
               end else begin
                  if (w_q == 2'd0) blk_d = '0;
                  for (int i = 0; i < WORDS_PER_BLK; i++) begin
                     if (w_q == 2'(i)) blk_d[BLK_W-1-WORD_W*i -: WORD_W] = s_data;
                  end
                  seg_kind_d = kind;
                  if (s_last) begin
                     w_d = 2'd0;
                     if ((w_q == 2'd3) && (s_bytes == 3'd4)) begin
                        blk_valid_d = 1'b1;
                        blk_k_n_d   = kind[0];
                        blk_a_p_d   = 1'b0;
                        state_d     = S_SEND;
                        ret_d       = S_KEY;
                        if (kind == KIND_KEY) key_seen_d   = 1'b1;
                        else                  nonce_seen_d = 1'b1;
                     end else begin
                        err_d = 1'b1;
                        blk_d = '0;
                     end
                  end else if (w_q == 2'd3) begin
                     err_d = 1'b1;
                     w_d   = 2'd0;
                     blk_d = '0;
                  end else begin
                     w_d = w_q + 2'd1;
                  end
               end
            end
         end

         S_GO: begin
            key_seen_d   = 1'b0;
            nonce_seen_d = 1'b0;
            state_d      = S_AD;
         end

         S_AD, S_PT: begin
            if (sep_stall) begin
               blk_d       = '0;
               blk_valid_d = 1'b1;
               blk_k_n_d   = 1'b0;
               blk_a_p_d   = 1'b1;
               state_d     = S_SEP;
            end else if (word_xfer) begin
               if (kind != data_kind) begin
                  err_d = 1'b1;
               end else if (s_last && !bytes_ok) begin
                  err_d = 1'b1;
               end else begin
                  if (w_q == 2'd0) blk_d = '0;
                  for (int i = 0; i < WORDS_PER_BLK; i++) begin
                     if (w_q == 2'(i)) blk_d[BLK_W-1-WORD_W*i -: WORD_W] = tail_word;
                  end
                  seg_kind_d = kind;
                  blk_k_n_d  = 1'b0;
                  blk_a_p_d  = 1'b0;
                  if (s_last) begin
                     blk_valid_d = 1'b1;
                     state_d     = S_SEND;
                     w_d         = 2'd0;
                     ret_d       = done_state;
                     if (s_bytes == 3'd4) begin
                        if (w_q == 2'd3) begin
                           ret_d = S_PAD;
                        end else begin
                           // Full last word with room left: pad lands in the next word.
                           for (int i = 1; i < WORDS_PER_BLK; i++) begin
                              if ({1'b0, w_q} + 3'd1 == 3'(i)) begin
                                 blk_d[BLK_W-1-WORD_W*i -: WORD_W] = {PAD_BYTE, 24'h0};
                              end
                           end
                        end
                     end
                  end else if (w_q == 2'd3) begin
                     blk_valid_d = 1'b1;
                     state_d     = S_SEND;
                     ret_d       = state_q;
                     w_d         = 2'd0;
                  end else begin
                     w_d = w_q + 2'd1;
                  end
               end
            end
         end

         S_SEP: begin
            if (blk_xfer) begin
               blk_valid_d = 1'b0;
               blk_a_p_d   = 1'b0;
               blk_d       = '0;
               state_d     = S_PT;
            end
         end

         S_PAD: begin
            blk_d       = {PAD_BYTE, {(BLK_W-8){1'b0}}};
            blk_valid_d = 1'b1;
            blk_k_n_d   = 1'b0;
            blk_a_p_d   = 1'b0;
            state_d     = S_SEND;
            ret_d       = (seg_kind_q == KIND_PT) ? S_KEY : S_AD;
         end

         S_SEND: begin
            if (blk_xfer) begin
               blk_valid_d = 1'b0;
               blk_k_n_d   = 1'b0;
               blk_d       = '0;
               if ((ret_q == S_KEY) && key_seen_q && nonce_seen_q) begin
                  state_d  = S_GO;
                  key_go_d = 1'b1;
               end else begin
                  state_d = ret_q;
               end
            end
         end

         default: state_d = S_KEY;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_KEY;
         ret_q        <= S_KEY;
         w_q          <= 2'd0;
         blk_q        <= '0;
         blk_valid_q  <= 1'b0;
         blk_k_n_q    <= 1'b0;
         blk_a_p_q    <= 1'b0;
         key_go_q     <= 1'b0;
         err_q        <= 1'b0;
         key_seen_q   <= 1'b0;
         nonce_seen_q <= 1'b0;
         seg_kind_q   <= KIND_KEY;
      end else begin
         state_q      <= state_d;
         ret_q        <= ret_d;
         w_q          <= w_d;
         blk_q        <= blk_d;
         blk_valid_q  <= blk_valid_d;
         blk_k_n_q    <= blk_k_n_d;
         blk_a_p_q    <= blk_a_p_d;
         key_go_q     <= key_go_d;
         err_q        <= err_d;
         key_seen_q   <= key_seen_d;
         nonce_seen_q <= nonce_seen_d;
         seg_kind_q   <= seg_kind_d;
      end
   end

   assign blk       = blk_q;
   assign blk_valid = blk_valid_q;
   assign blk_k_n   = blk_k_n_q;
   assign blk_a_p   = blk_a_p_q;
   assign key_go    = key_go_q;
   assign err       = err_q;

endmodule
